// File: rtl/keccak_pkg.sv
// Keccak-f shared constants: state geometry, rho rotation offsets and
// a flat-index offset lookup used by the inverse rho sequencer.
package keccak_pkg;

    localparam int ROW_SIZE  = 32'd5;
    localparam int COL_SIZE  = 32'd5;
    localparam int LANE_SIZE = 32'd64;
    localparam int NUM_LANES = ROW_SIZE * COL_SIZE;

    typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_t;

    // Rho rotation amounts indexed [x][y]; the forward step rotates left,
    // the inverse step rotates right by the same amount.
    localparam logic [5:0] RHO_OFFSETS [ROW_SIZE][COL_SIZE] = '{
        '{6'd0,  6'd36, 6'd3,  6'd41, 6'd18},
        '{6'd1,  6'd44, 6'd10, 6'd45, 6'd2 },
        '{6'd62, 6'd6,  6'd43, 6'd15, 6'd61},
        '{6'd28, 6'd55, 6'd25, 6'd21, 6'd56},
        '{6'd27, 6'd20, 6'd39, 6'd8,  6'd14}
    };

    // Offset for flattened lane index idx = x*5 + y.
    function automatic logic [5:0] rho_offset_flat(input logic [4:0] idx);
        logic [2:0] x;
        logic [2:0] y;
        x = 3'(idx / 5'd5);
        y = 3'(idx % 5'd5);
        return RHO_OFFSETS[x][y];
    endfunction

endpackage

// File: rtl/lane_rotr.sv
// Combinational right-rotation of one Keccak lane by a 6-bit amount.
module lane_rotr
    import keccak_pkg::*;
(
    input  logic [LANE_SIZE-1:0] i_lane,
    input  logic [5:0]           i_amt,
    output logic [LANE_SIZE-1:0] o_lane
);

    logic [6:0] w_lshift;

    // A zero amount makes the left shift 64, which clears that term.
    assign w_lshift = 7'd64 - {1'b0, i_amt};
    assign o_lane   = (i_lane >> i_amt) | (i_lane << w_lshift);

endmodule

// File: rtl/inv_rho_seq.sv
// Sequential inverse rho: captures a state, rotates LANES_PER_CYCLE lanes
// per cycle into the output register, then holds the result until taken.
module inv_rho_seq
    import keccak_pkg::*;
#(
    parameter int LANES_PER_CYCLE = 5
)
(
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]  state_array_in,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]  state_array_out
);

    localparam int         NUM_GROUPS = NUM_LANES / LANES_PER_CYCLE;
    localparam logic [4:0] LANES_W    = 5'(LANES_PER_CYCLE);
    localparam logic [4:0] LAST_GROUP = 5'(NUM_GROUPS - 1);

    generate
        if (!(LANES_PER_CYCLE == 1 || LANES_PER_CYCLE == 5 || LANES_PER_CYCLE == 25)) begin : g_bad_lanes
            $error("inv_rho_seq: LANES_PER_CYCLE must be 1, 5 or 25");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e                               r_state;
    logic [4:0]                         r_group;
    logic [NUM_LANES-1:0][LANE_SIZE-1:0] r_work;
    logic [NUM_LANES-1:0][LANE_SIZE-1:0] r_out;
    logic                               r_in_ready;
    logic                               r_out_valid;

    logic [4:0]           w_base;
    logic [4:0]           w_idx      [LANES_PER_CYCLE];
    logic [LANE_SIZE-1:0] w_lane_in  [LANES_PER_CYCLE];
    logic [5:0]           w_amt      [LANES_PER_CYCLE];
    logic [LANE_SIZE-1:0] w_lane_out [LANES_PER_CYCLE];

    // Select the lanes and offsets of the current group (flat index x*5+y).
    always_comb begin
        w_base = r_group * LANES_W;
        for (int j = 0; j < LANES_PER_CYCLE; j++) begin
            w_idx[j]     = w_base + 5'(j);
            w_lane_in[j] = r_work[w_idx[j]];
            w_amt[j]     = rho_offset_flat(w_idx[j]);
        end
    end

    for (genvar j = 0; j < LANES_PER_CYCLE; j++) begin : g_rotr
        lane_rotr u_lane_rotr (
            .i_lane (w_lane_in[j]),
            .i_amt  (w_amt[j]),
            .o_lane (w_lane_out[j])
        );
    end

    // Handshake FSM, group counter, working and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_group     <= 5'd0;
            r_work      <= '0;
            r_out       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work     <= state_array_in;
                        r_group    <= 5'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
                        r_out[w_idx[j]] <= w_lane_out[j];
                    end
                    if (r_group == LAST_GROUP) begin
                        r_group     <= 5'd0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_group <= r_group + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_group     <= 5'd0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = r_in_ready;
    assign out_valid       = r_out_valid;
    assign state_array_out = r_out;

endmodule

// File: tb/tb_inv_rho_seq.sv
// Scoreboard bench for inv_rho_seq with one instance per legal lane count.
`timescale 1ns/1ps
module tb_inv_rho_seq;
    import keccak_pkg::*;

    localparam int NI = 3;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   iv   [NI];
    logic   ir   [NI];
    logic   ov   [NI];
    logic   ordy [NI];
    state_t din  [NI];
    state_t dout [NI];

    state_t exp_q [$];
    int     checks   = 0;
    int     failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LPG = (g == 0) ? 1 : ((g == 1) ? 5 : 25);
        inv_rho_seq #(.LANES_PER_CYCLE(LPG)) u_dut (
            .clk             (clk),
            .rst             (rst),
            .in_valid        (iv[g]),
            .in_ready        (ir[g]),
            .state_array_in  (din[g]),
            .out_valid       (ov[g]),
            .out_ready       (ordy[g]),
            .state_array_out (dout[g])
        );
    end

    function automatic int n_groups(input int d);
        return (d == 0) ? 25 : ((d == 1) ? 5 : 1);
    endfunction

    // Forward rho: rotate each lane left by its offset.
    function automatic state_t rho_fwd(input state_t s);
        state_t r;
        int k;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                k = int'(RHO_OFFSETS[x][y]);
                if (k == 0) r[x][y] = s[x][y];
                else        r[x][y] = (s[x][y] << k) | (s[x][y] >> (64 - k));
            end
        end
        return r;
    endfunction

    function automatic state_t rand_state();
        state_t r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[x][y] = {$urandom, $urandom};
        return r;
    endfunction

    task automatic start_job(input int d, input state_t s, input state_t e, input bit push);
        int c;
        c = 0;
        while (ir[d] !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (ir[d] !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait d=%0d in_ready=%b want 1", d, ir[d]);
        end
        din[d] = s;
        iv[d]  = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        iv[d]  = 1'b0;
        din[d] = rand_state();
    endtask

    task automatic wait_out(input int d, output int lat);
        int c;
        bit busy_ready;
        c = 1;
        busy_ready = 1'b0;
        while (ov[d] !== 1'b1 && c < 40) begin
            if (ir[d] !== 1'b0) busy_ready = 1'b1;
            @(negedge clk);
            c++;
        end
        checks++;
        if (busy_ready) begin
            failures++;
            $display("FAIL in_ready_busy d=%0d in_ready=1 want 0", d);
        end
        lat = c;
    endtask

    task automatic run_job(input int d, input state_t s, input state_t e);
        int lat;
        state_t want;
        start_job(d, s, e, 1'b1);
        wait_out(d, lat);
        checks++;
        if (lat != n_groups(d) + 1) begin
            failures++;
            $display("FAIL latency d=%0d got=%0d want=%0d", d, lat, n_groups(d) + 1);
        end
        checks++;
        if (ir[d] !== 1'b0) begin
            failures++;
            $display("FAIL in_ready_done d=%0d got=%b want 0", d, ir[d]);
        end
        want = exp_q.pop_front();
        checks++;
        if (dout[d] !== want) begin
            failures++;
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    if (dout[d][x][y] !== want[x][y])
                        $display("FAIL data d=%0d lane[%0d][%0d] got=%h want=%h", d, x, y, dout[d][x][y], want[x][y]);
        end
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        checks++;
        if (ov[d] !== 1'b0) begin
            failures++;
            $display("FAIL out_valid_drop d=%0d got=%b want 0", d, ov[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || dout[d] !== '0) begin
                failures++;
                $display("FAIL reset_state d=%0d out_valid=%b out_nonzero=%b want 0/0", d, ov[d], dout[d] !== '0);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NI; d++) begin
            checks++;
            if (ir[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready d=%0d in_ready=%b want 1", d, ir[d]);
            end
        end
    endtask

    task automatic test_vectors();
        state_t s;
        state_t e;
        s = '0; s[0][1] = 64'h0000000000000001;
        e = '0; e[0][1] = 64'h0000000010000000;
        run_job(1, s, e);
        s = '0; e = '0;
        s[0][0] = 64'hDEADBEEFCAFEF00D; e[0][0] = 64'hDEADBEEFCAFEF00D;
        s[2][0] = 64'h0000000000000003; e[2][0] = 64'h000000000000000C;
        s[4][4] = 64'h0000000000000001; e[4][4] = 64'h0004000000000000;
        for (int d = 0; d < NI; d++) run_job(d, s, e);
    endtask

    task automatic test_stall();
        state_t s;
        state_t want;
        int lat;
        s = rand_state();
        start_job(1, rho_fwd(s), s, 1'b1);
        wait_out(1, lat);
        iv[1]   = 1'b1;
        din[1]  = rand_state();
        ordy[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (ov[1] !== 1'b1 || ir[1] !== 1'b0 || dout[1] !== exp_q[0]) begin
                failures++;
                $display("FAIL stall cyc=%0d out_valid=%b in_ready=%b data_ok=%b want 1/0/1", i, ov[1], ir[1], dout[1] === exp_q[0]);
            end
        end
        iv[1]   = 1'b0;
        ordy[1] = 1'b1;
        @(negedge clk);
        ordy[1] = 1'b0;
        want = exp_q.pop_front();
        checks++;
        if (ov[1] !== 1'b0 || ir[1] !== 1'b1 || dout[1] !== want) begin
            failures++;
            $display("FAIL stall_release out_valid=%b in_ready=%b data_ok=%b want 0/1/1", ov[1], ir[1], dout[1] === want);
        end
    endtask

    task automatic test_reset_mid_busy();
        state_t s;
        bit rose;
        s = rand_state();
        start_job(1, rho_fwd(s), s, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ov[1] !== 1'b0 || dout[1] !== '0) begin
            failures++;
            $display("FAIL rst_busy out_valid=%b out_nonzero=%b want 0/0", ov[1], dout[1] !== '0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ir[1] !== 1'b1) begin
            failures++;
            $display("FAIL rst_busy_ready in_ready=%b want 1", ir[1]);
        end
        rose = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov[1] !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose) begin
            failures++;
            $display("FAIL rst_busy_no_valid out_valid rose=1 want 0");
        end
        s = rand_state();
        run_job(1, rho_fwd(s), s);
    endtask

    task automatic test_random();
        state_t s;
        for (int d = 0; d < NI; d++) begin
            for (int i = 0; i < 1000; i++) begin
                s = rand_state();
                run_job(d, rho_fwd(s), s);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < NI; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b0;
            din[d]  = '0;
        end
        test_reset();
        test_vectors();
        test_stall();
        test_reset_mid_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_rho_seq.md
INV_RHO_SEQ -- requirements
Module: inv_rho_seq

Interface
REQ-001 Parameter: LANES_PER_CYCLE, default 5, lanes inverse-rotated per BUSY cycle; legal values 1, 5, 25.
REQ-002 Port: clk  input  1  sole clock, rising-edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  state_array_in holds a state to process.
REQ-005 Port: in_ready  output  1  block can accept a state this cycle.
REQ-006 Port: state_array_in  input  [ROW_SIZE][COL_SIZE][LANE_SIZE]  rho-rotated state, indexed [x][y].
REQ-007 Port: out_valid  output  1  state_array_out holds a finished result.
REQ-008 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-009 Port: state_array_out  output  [ROW_SIZE][COL_SIZE][LANE_SIZE]  inverse-rho result, registered.

Function
REQ-010 Each lane [x][y] SHALL be rotated right by RHO_OFFSETS[x][y] mod LANE_SIZE; offset 0 passes the lane unchanged.
REQ-011 For any state S, inv_rho_seq(rho_step(S)) SHALL equal S bit-exactly.
REQ-012 FSM states SHALL be IDLE, BUSY, DONE only.
REQ-013 IDLE: in_ready=1, out_valid=0; in_valid&in_ready at an edge captures state_array_in into a working register, clears group counter to 0, enters BUSY.
REQ-014 Input SHALL be sampled only at the accepting edge; later changes on state_array_in have no effect.
REQ-015 BUSY: each edge rotates group k = flattened lanes x*5+y in [k*L, (k+1)*L), writes them into the output register, increments k; N = 25/L groups.
REQ-016 The edge processing group N-1 SHALL transition to DONE; counter wraps to 0.
REQ-017 Latency: acceptance in cycle 0 -> out_valid high in cycle N+1 (cycle 6 for L=5, cycle 2 for L=25, cycle 26 for L=1).
REQ-018 DONE: out_valid=1, in_ready=0; state_array_out SHALL stay stable while out_valid&!out_ready.
REQ-019 DONE with out_ready=1 at an edge SHALL return to IDLE; out_valid falls next cycle, state_array_out retains last value.
REQ-020 in_ready SHALL be 0 in BUSY and DONE; no overlap of jobs; throughput one state per N+2 cycles minimum.
REQ-021 out_ready asserted outside DONE SHALL be ignored; in_valid outside IDLE SHALL be ignored.
REQ-022 Illegal LANES_PER_CYCLE SHALL cause an elaboration-time error.

Reset
REQ-023 rst high SHALL immediately force IDLE, counter=0, working and output registers all-zero, out_valid=0.
REQ-024 in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-025 rst during BUSY or DONE SHALL discard the in-flight state; no partial result is ever presented with out_valid=1.

Structure
REQ-026 RHO_OFFSETS [ROW_SIZE][COL_SIZE] SHALL live in keccak_pkg and be shared with the forward rho step; ROW_SIZE, COL_SIZE, LANE_SIZE come from keccak_pkg.
REQ-027 FSM enum type SHALL be local to the module.
REQ-028 One combinational sub-module lane_rotr (lane in, 6-bit amount in, lane out) SHALL be instantiated LANES_PER_CYCLE times, fed from a group-indexed lane/offset mux.

Verification
REQ-029 Lane[0][1]=0x0000000000000001, rest 0, L=5 -> out lane[0][1]=0x0000000010000000, all other lanes 0, out_valid in cycle 6.
REQ-030 Lane[0][0]=0xDEADBEEFCAFEF00D, lane[2][0]=0x3, lane[4][4]=0x1 -> outputs 0xDEADBEEFCAFEF00D, 0xC, 0x0004000000000000.
REQ-031 1000 random states through rho_step then inv_rho_seq, each L in {1,5,25} -> output equals original; latency N+1 every time.
REQ-032 out_ready held 0 for 10 cycles in DONE with in_valid=1 -> out_valid stays 1, data stable, in_ready stays 0, no second capture; out_ready=1 -> IDLE next cycle.
REQ-033 rst pulsed in BUSY cycle 3 (L=5) -> outputs zero, out_valid never rises for that job, in_ready=1 after deassert; next job completes correctly.
